// File: rtl/key_shift_conditioner.sv
// Synchronizes and debounces the active-low shift key and the data switch, giving one shift strobe per accepted press.
// Define AUTO_REPEAT_EN to add periodic repeat strobes while the key stays held.
module key_shift_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_n,
    input  logic       sw_in,
    output logic       shift_pulse,
    output logic       shift_bit,
    output logic       key_level,
    output logic [7:0] press_count
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] key_sync;
    logic [SYNC_STAGES-1:0] sw_sync;
    logic                   key_s;
    logic                   sw_s;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pulse_next;
    logic             bit_next;
    logic [7:0]       count_next;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic [REP_W-1:0] rep;
    logic [REP_W-1:0] rep_next;
`endif

    assign key_s = key_sync[SYNC_STAGES-1];
    assign sw_s  = sw_sync[SYNC_STAGES-1];

    // Key chain resets to released (1) so no phantom press follows reset release.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_sync <= '1;
            sw_sync  <= '0;
        end else begin
            key_sync <= {key_sync[SYNC_STAGES-2:0], key_n};
            sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw_in};
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;
        bit_next   = shift_bit;
        count_next = press_count;
`ifdef AUTO_REPEAT_EN
        rep_next   = rep;
`endif
        case (state)
            RELEASED: begin
                if (!key_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    pulse_next = 1'b1;
                    bit_next   = sw_s;
                    count_next = press_count + 8'd1;
`ifdef AUTO_REPEAT_EN
                    rep_next   = '0;
`endif
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
`ifdef AUTO_REPEAT_EN
                    rep_next   = '0;
                end else if (rep == REP_LAST) begin
                    pulse_next = 1'b1;
                    bit_next   = sw_s;
                    rep_next   = '0;
                end else begin
                    rep_next = rep + REP_ONE;
`endif
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = RELEASED;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    // key_level follows the next state so it lines up with the state register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= RELEASED;
            cnt         <= '0;
            shift_pulse <= 1'b0;
            shift_bit   <= 1'b0;
            key_level   <= 1'b0;
            press_count <= '0;
`ifdef AUTO_REPEAT_EN
            rep         <= '0;
`endif
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            shift_pulse <= pulse_next;
            shift_bit   <= bit_next;
            key_level   <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
            press_count <= count_next;
`ifdef AUTO_REPEAT_EN
            rep         <= rep_next;
`endif
        end
    end

endmodule

// File: tb/tb_key_shift_conditioner.sv
// Scoreboard bench for key_shift_conditioner: a run-length debounce model predicts strobes, a monitor checks them.
module tb_key_shift_conditioner;
    localparam int unsigned DEB  = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned REP  = 6;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       key_n;
    logic       sw_in;
    logic       shift_pulse;
    logic       shift_bit;
    logic       key_level;
    logic [7:0] press_count;

    key_shift_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES(SYNC),
        .REPEAT_CYCLES(REP)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .key_n(key_n),
        .sw_in(sw_in),
        .shift_pulse(shift_pulse),
        .shift_bit(shift_bit),
        .key_level(key_level),
        .press_count(press_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int unsigned cyc;
        bit          b;
        byte unsigned count;
    } exp_t;

    exp_t         exp_q[$];
    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  cyc = 0;
    int unsigned  pulses = 0;

    // Reference model state: what the key looks like after the synchronizer delay,
    // and how many consecutive samples have disagreed with the debounced level.
    bit           kq[$];
    bit           sq[$];
    bit           m_lvl = 1'b0;
    bit           m_bit = 1'b0;
    byte unsigned m_count = 8'd0;
    int unsigned  run = 0;
    int           rep = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            kq.delete();
            sq.delete();
            for (int unsigned i = 0; i < SYNC; i++) begin
                kq.push_back(1'b1);
                sq.push_back(1'b0);
            end
            m_lvl   = 1'b0;
            m_bit   = 1'b0;
            m_count = 8'd0;
            run     = 0;
            rep     = 0;
            exp_q.delete();
        end else begin
            bit ks;
            bit ss;
            bit pressed;
            cyc++;
            kq.push_back(key_n);
            sq.push_back(sw_in);
            ks = kq.pop_front();
            ss = sq.pop_front();
            pressed = !ks;
            if (pressed != m_lvl) run++;
            else run = 0;
            if (run == DEB + 1) begin
                m_lvl = !m_lvl;
                run   = 0;
                if (m_lvl) begin
                    m_count++;
                    m_bit = ss;
                    rep   = 0;
                    exp_q.push_back('{cyc, ss, m_count});
                end
            end else if (m_lvl) begin
`ifdef AUTO_REPEAT_EN
                if (!pressed) rep = -1;
                else begin
                    rep++;
                    if (rep == int'(REP)) begin
                        rep   = 0;
                        m_bit = ss;
                        exp_q.push_back('{cyc, ss, m_count});
                    end
                end
`endif
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_expected", 32'(shift_pulse), 1);
            check("bit_at_pulse", 32'(shift_bit), 32'(e.b));
            check("count_at_pulse", 32'(press_count), 32'(e.count));
        end else begin
            check("pulse_unexpected", 32'(shift_pulse), 0);
        end
        check("key_level", 32'(key_level), 32'(m_lvl));
        check("press_count", 32'(press_count), 32'(m_count));
        check("shift_bit", 32'(shift_bit), 32'(m_bit));
        if (shift_pulse) pulses++;
    end

    task automatic hold(input bit k, input bit s, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            key_n = k;
            sw_in = s;
        end
    endtask

    initial begin
        int unsigned p0;
        byte unsigned c0;
        reset = 1'b1;
        key_n = 1'b1;
        sw_in = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("reset_pulse", 32'(shift_pulse), 0);
        check("reset_bit", 32'(shift_bit), 0);
        check("reset_level", 32'(key_level), 0);
        check("reset_count", 32'(press_count), 0);
        reset = 1'b0;

        // clean press then release
        hold(1'b0, 1'b1, 12);
        hold(1'b1, 1'b1, 10);
        check("clean_count", 32'(press_count), 1);
        check("clean_bit", 32'(shift_bit), 1);

        // press bounce, then a held press
        hold(1'b0, 1'b0, 3);
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b1, 12);
        hold(1'b1, 1'b0, 10);
        check("bounce_count", 32'(press_count), 2);

        // release bounce keeps the key pressed; full release then press with sw low
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 2);
        hold(1'b0, 1'b1, 6);
        hold(1'b1, 1'b0, 10);
        check("release_bounce_count", 32'(press_count), 3);
        hold(1'b0, 1'b0, 10);
        hold(1'b1, 1'b0, 10);
        check("second_press_count", 32'(press_count), 4);
        check("second_press_bit", 32'(shift_bit), 0);

        // 256 presses wrap the counter back to where it started
        c0 = m_count;
        p0 = pulses;
        for (int unsigned i = 0; i < 256; i++) begin
            hold(1'b0, 1'($urandom), 7);
            hold(1'b1, 1'($urandom), 7);
        end
        hold(1'b1, 1'b0, 4);
        check("wrap_pulses", pulses - p0, 256);
        check("wrap_count", 32'(press_count), 32'(c0));

        // async reset during press debounce, key held through release
        hold(1'b0, 1'b1, 4);
        @(negedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        check("async_pulse", 32'(shift_pulse), 0);
        check("async_bit", 32'(shift_bit), 0);
        check("async_level", 32'(key_level), 0);
        check("async_count", 32'(press_count), 0);
        hold(1'b0, 1'b1, 3);
        reset = 1'b0;
        p0 = pulses;
        hold(1'b0, 1'b1, 12);
        hold(1'b1, 1'b0, 10);
        check("post_reset_pulses", pulses - p0, 1);
        check("post_reset_count", 32'(press_count), 1);

        // long hold: repeat strobes only when the feature is built in
        p0 = pulses;
        hold(1'b0, 1'b1, 25);
        hold(1'b1, 1'b1, 10);
`ifdef AUTO_REPEAT_EN
        check("hold_pulses", pulses - p0, 4);
`else
        check("hold_pulses", pulses - p0, 1);
`endif
        check("hold_count", 32'(press_count), 2);

        // random key/switch activity including short glitches
        for (int unsigned seg = 0; seg < 300; seg++) begin
            int unsigned len;
            len = $urandom_range(1, 9);
            for (int unsigned i = 0; i < len; i++) begin
                @(negedge CLOCK_50);
                key_n = 1'(seg % 2);
                sw_in = 1'($urandom);
            end
        end
        hold(1'b1, 1'b0, 20);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
